// File: rtl/event_pkg.sv
// Shared event type and sizing helpers for the DVS tile router.
package event_pkg;

  localparam int XY_BITS = 10;
  localparam int T_BITS  = 32;

  localparam int DEFAULT_SENSOR_WIDTH  = 640;
  localparam int DEFAULT_SENSOR_HEIGHT = 480;

  typedef struct packed {
    logic [XY_BITS-1:0] x;
    logic [XY_BITS-1:0] y;
    logic               p;
    logic [T_BITS-1:0]  t;
  } event_t;

  // A single-tile grid still needs a one-bit index.
  function automatic int tileIdxBits(input int numTiles);
    return (numTiles > 1) ? $clog2(numTiles) : 1;
  endfunction

endpackage

// File: rtl/tile_fifo.sv
// Per-tile event FIFO: registered storage, no fall-through, extra-MSB pointers.
module tile_fifo
  import event_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  event_t pushData_i,
  output logic   full_o,
  input  logic   pop_i,
  output event_t head_o,
  output logic   valid_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  event_t        mem_q [FIFO_DEPTH];
  logic [AW:0]   wrPtr_q, wrPtr_d;
  logic [AW:0]   rdPtr_q, rdPtr_d;
  logic          empty;
  logic          doPush;
  logic          doPop;

  // Full is judged before any same-cycle pop, so a push to a full FIFO never slips in.
  assign empty  = (wrPtr_q == rdPtr_q);
  assign full_o = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + (AW+1)'(1);
    if (doPop)  rdPtr_d = rdPtr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
  end

  assign head_o  = mem_q[rdPtr_q[AW-1:0]];
  assign valid_o = !empty;

endmodule

// File: rtl/event_tile_router.sv
// Routes DVS events into per-tile FIFOs through one registered routing stage.
// Define EVENT_ROUTER_DROP_EN to discard events for full tiles instead of stalling.
module event_tile_router
  import event_pkg::*;
#(
  parameter int  SENSOR_WIDTH  = DEFAULT_SENSOR_WIDTH,
  parameter int  SENSOR_HEIGHT = DEFAULT_SENSOR_HEIGHT,
  parameter int  X_DIVISIONS   = 4,
  parameter int  Y_DIVISIONS   = 2,
  parameter int  FIFO_DEPTH    = 8,
  localparam int NUM_TILES     = X_DIVISIONS * Y_DIVISIONS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  event_t                 in_event,
  input  logic                   in_valid,
  output logic                   in_ready,
  output event_t [NUM_TILES-1:0] out_event,
  output logic   [NUM_TILES-1:0] out_valid,
  input  logic   [NUM_TILES-1:0] out_ready,
  output logic                   oob_err,
  output logic   [31:0]          drop_count
);

  localparam int TILE_W = SENSOR_WIDTH / X_DIVISIONS;
  localparam int TILE_H = SENSOR_HEIGHT / Y_DIVISIONS;
  localparam int TIDX_W = tileIdxBits(NUM_TILES);

  logic               s1Valid_q, s1Valid_d;
  event_t             s1Event_q, s1Event_d;
  logic [TIDX_W-1:0]  s1Tile_q, s1Tile_d;
  logic               oobErr_q, oobErr_d;

  logic [TIDX_W-1:0]    routeTile;
  logic                 routeOob;
  logic [NUM_TILES-1:0] fifoFull;
  logic [NUM_TILES-1:0] fifoPush;
  logic                 targetFull;
  logic                 s1Advance;
  logic                 pushEn;
  logic                 accept;

  // Comparator chain; out-of-range and remainder coordinates land in the last column/row.
  always_comb begin : route
    int tx;
    int ty;
    tx = 0;
    ty = 0;
    for (int i = 1; i < X_DIVISIONS; i++) begin
      if (int'(in_event.x) >= i * TILE_W) tx = i;
    end
    for (int j = 1; j < Y_DIVISIONS; j++) begin
      if (int'(in_event.y) >= j * TILE_H) ty = j;
    end
    routeTile = TIDX_W'(ty * X_DIVISIONS + tx);
    routeOob  = (int'(in_event.x) >= SENSOR_WIDTH) || (int'(in_event.y) >= SENSOR_HEIGHT);
  end

  assign targetFull = fifoFull[s1Tile_q];

`ifdef EVENT_ROUTER_DROP_EN
  logic [31:0] dropCount_q, dropCount_d;

  assign s1Advance = s1Valid_q;
  assign pushEn    = s1Valid_q && !targetFull;
  assign in_ready  = !rst;

  always_comb begin
    dropCount_d = dropCount_q;
    if (s1Valid_q && targetFull && (dropCount_q != 32'hFFFF_FFFF)) dropCount_d = dropCount_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dropCount_q <= '0;
    else     dropCount_q <= dropCount_d;
  end

  assign drop_count = dropCount_q;
`else
  assign s1Advance  = s1Valid_q && !targetFull;
  assign pushEn     = s1Advance;
  assign in_ready   = !rst && (!s1Valid_q || s1Advance);
  assign drop_count = '0;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin : s1_next
    s1Valid_d = s1Valid_q;
    s1Event_d = s1Event_q;
    s1Tile_d  = s1Tile_q;
    oobErr_d  = accept && routeOob;
    if (s1Advance) s1Valid_d = 1'b0;
    if (accept) begin
      s1Valid_d = 1'b1;
      s1Event_d = in_event;
      s1Tile_d  = routeTile;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1Event_q <= '0;
      s1Tile_q  <= '0;
      oobErr_q  <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Event_q <= s1Event_d;
      s1Tile_q  <= s1Tile_d;
      oobErr_q  <= oobErr_d;
    end
  end

  assign oob_err = oobErr_q;

  for (genvar g = 0; g < NUM_TILES; g++) begin : g_tile
    assign fifoPush[g] = pushEn && (s1Tile_q == TIDX_W'(g));

    tile_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (fifoPush[g]),
      .pushData_i(s1Event_q),
      .full_o    (fifoFull[g]),
      .pop_i     (out_ready[g]),
      .head_o    (out_event[g]),
      .valid_o   (out_valid[g])
    );
  end

endmodule

// File: tb/tb_event_tile_router.sv
// Self-checking bench for event_tile_router against a queue-based tile routing model.
module tb_event_tile_router;
  import event_pkg::*;

  localparam int SW = 640;
  localparam int SH = 480;
  localparam int XD = 4;
  localparam int YD = 2;
  localparam int DEPTH = 8;
  localparam int NT = XD * YD;
  localparam int TW = SW / XD;
  localparam int TH = SH / YD;

  logic             clk = 1'b0;
  logic             rst;
  event_t           in_event;
  logic             in_valid;
  logic             in_ready;
  event_t [NT-1:0]  out_event;
  logic   [NT-1:0]  out_valid;
  logic   [NT-1:0]  out_ready;
  logic             oob_err;
  logic   [31:0]    drop_count;

  int nCompared   = 0;
  int nMismatched = 0;

  event_t expQ [NT][$];

  always #5 clk = ~clk;

  event_tile_router #(
    .SENSOR_WIDTH (SW),
    .SENSOR_HEIGHT(SH),
    .X_DIVISIONS  (XD),
    .Y_DIVISIONS  (YD),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_event  (in_event),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_event (out_event),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .oob_err   (oob_err),
    .drop_count(drop_count)
  );

  // Reference mapping: integer division of the coordinate, clamped to the last tile column/row.
  function automatic int refTile(input int x, input int y);
    int tx;
    int ty;
    tx = x / TW;
    ty = y / TH;
    if (tx > XD - 1) tx = XD - 1;
    if (ty > YD - 1) ty = YD - 1;
    return ty * XD + tx;
  endfunction

  function automatic event_t randEvent(input int xlo, input int xhi, input int ylo, input int yhi);
    event_t ev;
    ev.x = XY_BITS'($urandom_range(xhi, xlo));
    ev.y = XY_BITS'($urandom_range(yhi, ylo));
    ev.p = 1'($urandom_range(1, 0));
    ev.t = $urandom;
    return ev;
  endfunction

  // Call just after a rising edge; returns just after the accepting edge. waited > maxWait means never accepted.
  task automatic drive_event(input event_t ev, input int maxWait, output int waited);
    bit rdy;
    in_event = ev;
    in_valid = 1'b1;
    waited   = 0;
    while (1) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waited++;
      if (waited > maxWait) break;
    end
    in_valid = 1'b0;
  endtask

  task automatic clear_model();
    for (int t = 0; t < NT; t++) expQ[t].delete();
  endtask

  task automatic test_reset();
    int     w;
    event_t ev;
    logic [NT-1:0] expVec;
    rst = 1'b1; in_valid = 1'b0; out_ready = '0; in_event = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    nCompared++; if (out_valid !== '0) begin nMismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    nCompared++; if (oob_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_oob_err: got %b expected 0", oob_err); end
    nCompared++; if (drop_count !== 32'd0) begin nMismatched++; $display("[TB] FAIL reset_drop_count: got %0d expected 0", drop_count); end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_event(randEvent(0, TW - 1, 0, TH - 1), 4, w);
      nCompared++; if (w !== 0) begin nMismatched++; $display("[TB] FAIL prefill_accept[%0d]: waited %0d expected 0", i, w); end
    end
    @(negedge clk);
    nCompared++; if (out_valid[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL prefill_valid: got %b expected 1", out_valid[0]); end
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL midreset_in_ready: got %b expected 0", in_ready); end
    nCompared++; if (out_valid !== '0) begin nMismatched++; $display("[TB] FAIL midreset_out_valid: got %b expected 0", out_valid); end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    nCompared++; if (out_valid !== '0) begin nMismatched++; $display("[TB] FAIL postreset_out_valid: got %b expected 0", out_valid); end
    nCompared++; if (drop_count !== 32'd0) begin nMismatched++; $display("[TB] FAIL postreset_drop_count: got %0d expected 0", drop_count); end
    @(posedge clk); #1;
    ev = randEvent(3 * TW, SW - 1, 0, TH - 1);
    drive_event(ev, 4, w);
    nCompared++; if (w !== 0) begin nMismatched++; $display("[TB] FAIL postreset_accept: waited %0d expected 0", w); end
    @(negedge clk);
    nCompared++; if (out_valid !== '0) begin nMismatched++; $display("[TB] FAIL postreset_n1_valid: got %b expected 0", out_valid); end
    @(negedge clk);
    expVec = '0; expVec[refTile(ev.x, ev.y)] = 1'b1;
    nCompared++; if (out_valid !== expVec) begin nMismatched++; $display("[TB] FAIL postreset_n2_valid: got %b expected %b", out_valid, expVec); end
    nCompared++; if (out_event[3] !== ev) begin nMismatched++; $display("[TB] FAIL postreset_n2_event: got %h expected %h", out_event[3], ev); end
    out_ready = '1;
    @(posedge clk); #1;
  endtask

  task automatic test_mapping_oob();
    int xs [7] = '{0, 159, 160, 170, 639, 700, 5};
    int ys [7] = '{0, 0, 0, 250, 479, 10, 480};
    int w;
    int expTile;
    logic expOob;
    event_t ev;
    logic [NT-1:0] expVec;
    out_ready = '1;
    for (int i = 0; i < 7; i++) begin
      ev.x = XY_BITS'(xs[i]);
      ev.y = XY_BITS'(ys[i]);
      ev.p = 1'($urandom_range(1, 0));
      ev.t = $urandom;
      expTile = refTile(xs[i], ys[i]);
      expOob  = (xs[i] >= SW) || (ys[i] >= SH);
      expVec  = '0; expVec[expTile] = 1'b1;
      drive_event(ev, 4, w);
      nCompared++; if (w !== 0) begin nMismatched++; $display("[TB] FAIL map_accept[%0d]: waited %0d expected 0", i, w); end
      @(negedge clk);
      nCompared++; if (oob_err !== expOob) begin nMismatched++; $display("[TB] FAIL map_oob_n1[%0d]: got %b expected %b", i, oob_err, expOob); end
      nCompared++; if (out_valid !== '0) begin nMismatched++; $display("[TB] FAIL map_valid_n1[%0d]: got %b expected 0", i, out_valid); end
      @(negedge clk);
      nCompared++; if (out_valid !== expVec) begin nMismatched++; $display("[TB] FAIL map_valid_n2[%0d]: got %b expected %b", i, out_valid, expVec); end
      nCompared++; if (out_event[expTile] !== ev) begin nMismatched++; $display("[TB] FAIL map_event[%0d]: got %h expected %h", i, out_event[expTile], ev); end
      nCompared++; if (oob_err !== 1'b0) begin nMismatched++; $display("[TB] FAIL map_oob_n2[%0d]: got %b expected 0", i, oob_err); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int     w;
    int     recv;
    int     cyc;
    bit     rdy;
    event_t ev;
    event_t ev9;
    event_t exp;
    clear_model();
    out_ready = '0;
    for (int i = 0; i < 9; i++) begin
      ev = randEvent(2 * TW, 3 * TW - 1, 0, TH - 1);
      drive_event(ev, 4, w);
      nCompared++; if (w !== 0) begin nMismatched++; $display("[TB] FAIL bp_accept[%0d]: waited %0d expected 0", i, w); end
      expQ[2].push_back(ev);
    end
    ev9 = randEvent(2 * TW, 3 * TW - 1, 0, TH - 1);
    in_event = ev9;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nCompared++; if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_stall_ready[%0d]: got %b expected 0", c, in_ready); end
    end
    nCompared++; if (out_valid !== (NT'(1) << 2)) begin nMismatched++; $display("[TB] FAIL bp_stall_valid: got %b expected %b", out_valid, NT'(1) << 2); end
    out_ready[2] = 1'b1;
    recv = 0;
    cyc  = 0;
    while (recv < 10 && cyc < 60) begin
      rdy = in_ready;
      if (out_valid[2]) begin
        nCompared++;
        if (expQ[2].size() == 0) begin
          nMismatched++; $display("[TB] FAIL bp_unexpected: got %h expected none", out_event[2]);
        end else begin
          exp = expQ[2].pop_front();
          if (out_event[2] !== exp) begin nMismatched++; $display("[TB] FAIL bp_order[%0d]: got %h expected %h", recv, out_event[2], exp); end
        end
        recv++;
      end
      @(posedge clk); #1;
      if (in_valid && rdy) begin in_valid = 1'b0; expQ[2].push_back(ev9); end
      @(negedge clk);
      cyc++;
    end
    nCompared++; if (recv !== 10 || expQ[2].size() !== 0) begin nMismatched++; $display("[TB] FAIL bp_count: got %0d expected 10", recv); end
    in_valid  = 1'b0;
    out_ready = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_hol();
    int     w;
    int     recv1;
    int     recv2;
    int     cyc;
    bit     rdy;
    event_t ev;
    event_t ev1;
    event_t exp;
    clear_model();
    out_ready = '0;
`ifdef EVENT_ROUTER_DROP_EN
    for (int i = 0; i < 10; i++) begin
      ev = randEvent(2 * TW, 3 * TW - 1, 0, TH - 1);
      drive_event(ev, 4, w);
      nCompared++; if (w !== 0) begin nMismatched++; $display("[TB] FAIL hol_accept[%0d]: waited %0d expected 0", i, w); end
      if (i < DEPTH) expQ[2].push_back(ev);
    end
    ev1 = randEvent(TW, 2 * TW - 1, 0, TH - 1);
    drive_event(ev1, 4, w);
    nCompared++; if (w !== 0) begin nMismatched++; $display("[TB] FAIL hol_t1_accept: waited %0d expected 0", w); end
    @(negedge clk);
    @(negedge clk);
    nCompared++; if (out_valid[1] !== 1'b1 || out_event[1] !== ev1) begin nMismatched++; $display("[TB] FAIL hol_t1_n2: got %b/%h expected 1/%h", out_valid[1], out_event[1], ev1); end
    nCompared++; if (drop_count !== 32'd2) begin nMismatched++; $display("[TB] FAIL hol_drop_count: got %0d expected 2", drop_count); end
    out_ready[1] = 1'b1;
    out_ready[2] = 1'b1;
    recv1 = 1;
    recv2 = 0;
    @(posedge clk); #1;
    @(negedge clk);
`else
    for (int i = 0; i < 9; i++) begin
      ev = randEvent(2 * TW, 3 * TW - 1, 0, TH - 1);
      drive_event(ev, 4, w);
      nCompared++; if (w !== 0) begin nMismatched++; $display("[TB] FAIL hol_accept[%0d]: waited %0d expected 0", i, w); end
      expQ[2].push_back(ev);
    end
    ev1 = randEvent(TW, 2 * TW - 1, 0, TH - 1);
    in_event = ev1;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      nCompared++; if (out_valid[1] !== 1'b0 || in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL hol_blocked[%0d]: got valid1=%b ready=%b expected 0/0", c, out_valid[1], in_ready); end
    end
    out_ready[1] = 1'b1;
    out_ready[2] = 1'b1;
    recv1 = 0;
    recv2 = 0;
`endif
    cyc = 0;
    while ((recv1 < 1 || recv2 < DEPTH + (DEPTH == 8 ? 1 : 0) - 1 + 1 - ((recv1 == 1) ? 0 : 0)) && cyc < 60) begin
      rdy = in_ready;
      for (int t = 1; t <= 2; t++) begin
        if (out_valid[t]) begin
          nCompared++;
          if (expQ[t].size() == 0) begin
            nMismatched++; $display("[TB] FAIL hol_unexpected[%0d]: got %h expected none", t, out_event[t]);
          end else begin
            exp = expQ[t].pop_front();
            if (out_event[t] !== exp) begin nMismatched++; $display("[TB] FAIL hol_order[%0d]: got %h expected %h", t, out_event[t], exp); end
          end
          if (t == 1) recv1++;
          else        recv2++;
        end
      end
      @(posedge clk); #1;
      if (in_valid && rdy) begin in_valid = 1'b0; expQ[1].push_back(ev1); end
      @(negedge clk);
      cyc++;
    end
`ifdef EVENT_ROUTER_DROP_EN
    nCompared++; if (recv1 !== 1 || recv2 !== DEPTH) begin nMismatched++; $display("[TB] FAIL hol_count: got %0d/%0d expected 1/%0d", recv1, recv2, DEPTH); end
`else
    nCompared++; if (recv1 !== 1 || recv2 !== DEPTH + 1) begin nMismatched++; $display("[TB] FAIL hol_count: got %0d/%0d expected 1/%0d", recv1, recv2, DEPTH + 1); end
`endif
    in_valid  = 1'b0;
    out_ready = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_throughput();
    int recvTotal;
    clear_model();
    out_ready = '1;
    recvTotal = 0;
    fork
      begin
        int     w;
        event_t ev;
        for (int i = 0; i < 200; i++) begin
          ev = randEvent(0, 700, 0, 520);
          drive_event(ev, 4, w);
          nCompared++; if (w !== 0) begin nMismatched++; $display("[TB] FAIL tput_accept[%0d]: waited %0d expected 0", i, w); end
          expQ[refTile(ev.x, ev.y)].push_back(ev);
        end
      end
      begin
        event_t exp;
        for (int c = 0; c < 215; c++) begin
          @(negedge clk);
          for (int t = 0; t < NT; t++) begin
            if (out_valid[t]) begin
              nCompared++;
              if (expQ[t].size() == 0) begin
                nMismatched++; $display("[TB] FAIL tput_unexpected[%0d]: got %h expected none", t, out_event[t]);
              end else begin
                exp = expQ[t].pop_front();
                if (out_event[t] !== exp) begin nMismatched++; $display("[TB] FAIL tput_order[%0d]: got %h expected %h", t, out_event[t], exp); end
              end
              recvTotal++;
            end
          end
        end
      end
    join
    nCompared++; if (recvTotal !== 200) begin nMismatched++; $display("[TB] FAIL tput_count: got %0d expected 200", recvTotal); end
    out_ready = '0;
  endtask

  initial begin
    test_reset();
    test_mapping_oob();
`ifndef EVENT_ROUTER_DROP_EN
    test_backpressure();
`endif
    test_hol();
    test_throughput();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
